// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-core round-robin arbiter onto a single memory port
module mem_arbiter #(
  parameter int WORD_W   = 32,
  parameter int MAX_WAIT = 255,
  parameter int RR_INIT  = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [1:0]        iREN,
  input  logic [1:0]        dREN,
  input  logic [1:0]        dWEN,
  input  logic [WORD_W-1:0] iaddr0,
  input  logic [WORD_W-1:0] iaddr1,
  input  logic [WORD_W-1:0] daddr0,
  input  logic [WORD_W-1:0] daddr1,
  input  logic [WORD_W-1:0] dstore0,
  input  logic [WORD_W-1:0] dstore1,
  output logic [1:0]        iwait,
  output logic [1:0]        dwait,
  output logic [WORD_W-1:0] iload,
  output logic [WORD_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              memerr
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

  typedef enum logic {IDLE, SERVE} state_t;
  typedef enum logic [1:0] {DATA_RD = 2'd0, DATA_WR = 2'd1, INSTR = 2'd2} kind_t;

  localparam logic [1:0] RS_ERROR = 2'd3;

  state_t           state_q, state_d;
  kind_t            kind_q, kind_d;
  logic             core_q, core_d;
  logic             rr_q, rr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0] req_any;
  logic       pick_core;
  kind_t      pick_kind;
  logic       held;
  logic       active;
  logic       done;
  logic       timeout;

  // Arbitration choice, grant liveness, completion and abort detection
  always_comb begin
    req_any   = iREN | dREN | dWEN;
    pick_core = req_any[rr_q] ? rr_q : ~rr_q;
    if (dWEN[pick_core]) begin
      pick_kind = DATA_WR;
    end else if (dREN[pick_core]) begin
      pick_kind = DATA_RD;
    end else begin
      pick_kind = INSTR;
    end
    case (kind_q)
      DATA_WR: held = dWEN[core_q];
      DATA_RD: held = dREN[core_q];
      default: held = iREN[core_q];
    endcase
    active  = (state_q == SERVE) && held;
    // ACCESS and ERROR both have bit 1 set
    done    = active && ramstate[1];
    timeout = active && !ramstate[1] && (cnt_q == CNT_LAST);
  end

  // Next-state, grant, round-robin pointer and wait counter
  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    core_d  = core_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (|req_any) begin
          state_d = SERVE;
          core_d  = pick_core;
          kind_d  = pick_kind;
          cnt_d   = '0;
        end
      end
      default: begin
        if (!held) begin
          state_d = IDLE;
        end else if (done || timeout) begin
          state_d = IDLE;
          rr_d    = ~core_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  // State and grant registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      kind_q  <= DATA_RD;
      core_q  <= 1'b0;
      rr_q    <= 1'(RR_INIT);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      core_q  <= core_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Memory-side strobes and muxed address/data from the granted core
  always_comb begin
    ramREN   = active && (kind_q != DATA_WR);
    ramWEN   = active && (kind_q == DATA_WR);
    ramaddr  = '0;
    ramstore = '0;
    if (active) begin
      if (kind_q == INSTR) begin
        ramaddr = core_q ? iaddr1 : iaddr0;
      end else begin
        ramaddr = core_q ? daddr1 : daddr0;
      end
      ramstore = core_q ? dstore1 : dstore0;
    end
    memerr = (done && (ramstate == RS_ERROR)) || timeout;
  end

  // Requester stalls: released only for the access completing this cycle
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      iwait[c] = iREN[c] &
                 ~(done && (kind_q == INSTR) && (core_q == 1'(c)));
      dwait[c] = (dREN[c] | dWEN[c]) &
                 ~(done && (kind_q != INSTR) && (core_q == 1'(c)));
    end
    iload = ramload;
    dload = ramload;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic [1:0]  iREN, dREN, dWEN;
  logic [31:0] iaddr0, iaddr1, daddr0, daddr1, dstore0, dstore1;
  logic [1:0]  iwait, dwait;
  logic [31:0] iload, dload;
  logic        ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore, ramload;
  logic [1:0]  ramstate;
  logic        memerr;

  int tests = 0;
  int fails = 0;

  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2;

  mem_arbiter #(.WORD_W(32), .MAX_WAIT(4), .RR_INIT(0)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
    .iaddr0(iaddr0), .iaddr1(iaddr1), .daddr0(daddr0), .daddr1(daddr1),
    .dstore0(dstore0), .dstore1(dstore1),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .memerr(memerr)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge CLK);
  endtask

  initial begin
    RST = 1'b1;
    iREN = '0; dREN = '0; dWEN = '0;
    iaddr0 = '0; iaddr1 = '0; daddr0 = '0; daddr1 = '0;
    dstore0 = '0; dstore1 = '0;
    ramload = 32'h1234_5678; ramstate = FREE;
    nxt(); nxt(); #1;
    chk("rst_ramREN", ramREN, 0);
    chk("rst_ramWEN", ramWEN, 0);
    chk("rst_ramaddr", ramaddr, 0);
    chk("rst_memerr", memerr, 0);
    chk("rst_iwait", iwait, 0);
    nxt(); RST = 1'b0;

    // single instruction read, core0
    nxt(); iREN = 2'b01; iaddr0 = 32'h100; #1;
    chk("t1_idle_ramREN", ramREN, 0);
    chk("t1_idle_iwait", iwait, 2'b01);
    nxt(); ramstate = ACCESS; #1;
    chk("t1_ramREN", ramREN, 1);
    chk("t1_ramaddr", ramaddr, 32'h100);
    chk("t1_iwait", iwait, 2'b00);
    chk("t1_iload", iload, 32'h1234_5678);
    nxt(); iREN = 2'b00; ramstate = FREE; #1;
    chk("t1_back_idle", ramREN, 0);

    // core1 instruction read, returns priority to core0
    nxt(); iREN = 2'b10; iaddr1 = 32'h200; #1;
    nxt(); ramstate = ACCESS; #1;
    chk("t1b_ramaddr", ramaddr, 32'h200);
    chk("t1b_iwait", iwait, 2'b00);
    nxt(); iREN = 2'b00; ramstate = FREE;

    // both cores data read, core0 first with two BUSY cycles
    nxt(); dREN = 2'b11; daddr0 = 32'h10; daddr1 = 32'h20; ramstate = BUSY; #1;
    chk("t2_n_dwait", dwait, 2'b11);
    chk("t2_n_ramREN", ramREN, 0);
    nxt(); #1;
    chk("t2_n1_ramREN", ramREN, 1);
    chk("t2_n1_ramaddr", ramaddr, 32'h10);
    chk("t2_n1_dwait", dwait, 2'b11);
    nxt(); #1;
    chk("t2_n2_dwait", dwait, 2'b11);
    nxt(); ramstate = ACCESS; #1;
    chk("t2_n3_dwait", dwait, 2'b10);
    chk("t2_n3_ramaddr", ramaddr, 32'h10);
    nxt(); dREN = 2'b10; ramstate = BUSY; #1;
    chk("t2_n4_ramREN", ramREN, 0);
    chk("t2_n4_dwait", dwait, 2'b10);
    nxt(); ramstate = ACCESS; #1;
    chk("t2_n5_ramREN", ramREN, 1);
    chk("t2_n5_ramaddr", ramaddr, 32'h20);
    chk("t2_n5_dwait", dwait, 2'b00);
    nxt(); dREN = 2'b00; ramstate = FREE;

    // core1 write wins over read and instruction
    nxt(); dWEN = 2'b10; dREN = 2'b10; iREN = 2'b10;
    daddr1 = 32'h40; dstore1 = 32'hDEAD_BEEF; iaddr1 = 32'h300; #1;
    nxt(); ramstate = ACCESS; #1;
    chk("t3_ramWEN", ramWEN, 1);
    chk("t3_ramREN", ramREN, 0);
    chk("t3_ramaddr", ramaddr, 32'h40);
    chk("t3_ramstore", ramstore, 32'hDEAD_BEEF);
    chk("t3_dwait", dwait, 2'b00);
    chk("t3_iwait", iwait, 2'b10);
    nxt(); dWEN = 2'b00; dREN = 2'b00; ramstate = FREE; #1;
    chk("t3_idle_ramREN", ramREN, 0);
    chk("t3_idle_iwait", iwait, 2'b10);
    nxt(); ramstate = ACCESS; #1;
    chk("t3_i_ramREN", ramREN, 1);
    chk("t3_i_ramaddr", ramaddr, 32'h300);
    chk("t3_i_iwait", iwait, 2'b00);
    nxt(); iREN = 2'b00; ramstate = FREE;

    // timeout after MAX_WAIT SERVE cycles
    nxt(); dREN = 2'b01; daddr0 = 32'h50; ramstate = BUSY; #1;
    nxt(); #1; chk("t4_c1_memerr", memerr, 0);
    nxt(); #1; chk("t4_c2_memerr", memerr, 0);
    nxt(); #1; chk("t4_c3_memerr", memerr, 0);
    nxt(); #1;
    chk("t4_c4_memerr", memerr, 1);
    chk("t4_c4_dwait", dwait, 2'b01);
    chk("t4_c4_ramREN", ramREN, 1);
    nxt(); #1;
    chk("t4_idle_ramREN", ramREN, 0);
    chk("t4_idle_memerr", memerr, 0);
    // regranted, then dropped mid-SERVE
    nxt(); #1;
    chk("t4_regrant_ramREN", ramREN, 1);
    dREN = 2'b00; #1;
    chk("t4_drop_ramREN", ramREN, 0);
    chk("t4_drop_dwait", dwait, 2'b00);
    chk("t4_drop_memerr", memerr, 0);
    // pointer flipped by the abort, unchanged by the drop
    nxt(); iREN = 2'b11; iaddr0 = 32'h500; iaddr1 = 32'h600; #1;
    nxt(); ramstate = ACCESS; #1;
    chk("t4_rr_ramaddr", ramaddr, 32'h600);
    chk("t4_rr_iwait", iwait, 2'b01);
    nxt(); iREN = 2'b00; ramstate = FREE;

    // reset mid-SERVE during a write
    nxt(); iREN = 2'b01; iaddr0 = 32'h700; #1;
    nxt(); ramstate = ACCESS; #1;
    chk("t5_pre_iwait", iwait, 2'b00);
    nxt(); iREN = 2'b00; ramstate = BUSY; dWEN = 2'b11;
    daddr0 = 32'h60; daddr1 = 32'h70; dstore0 = 32'h11; dstore1 = 32'h22; #1;
    nxt(); #1;
    chk("t5_ramWEN", ramWEN, 1);
    chk("t5_ramaddr", ramaddr, 32'h70);
    chk("t5_ramstore", ramstore, 32'h22);
    #2; RST = 1'b1; #1;
    chk("t5_rst_ramWEN", ramWEN, 0);
    chk("t5_rst_ramaddr", ramaddr, 0);
    chk("t5_rst_ramstore", ramstore, 0);
    chk("t5_rst_memerr", memerr, 0);
    nxt(); RST = 1'b0; #1;
    chk("t5_rel_ramWEN", ramWEN, 0);
    chk("t5_rel_dwait", dwait, 2'b11);
    nxt(); ramstate = ACCESS; #1;
    chk("t5_regrant_ramWEN", ramWEN, 1);
    chk("t5_regrant_ramaddr", ramaddr, 32'h60);
    chk("t5_regrant_ramstore", ramstore, 32'h11);
    chk("t5_regrant_dwait", dwait, 2'b10);
    nxt(); dWEN = 2'b00; ramstate = FREE;
    nxt();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
